// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and default widths for the backprop sequencer
package bp_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LAYER,
    SAMPLE,
    RD_Z,
    Z,
    RD_ZP,
    ZP,
    WGT,
    NEXT
  } state_t;

  localparam int NEURON_NUM_DEF          = 4;
  localparam int NEURON_OUTPUT_WIDTH_DEF = 10;
  localparam int WEIGHT_CELL_WIDTH_DEF   = 16;
  localparam int LAYER_ADDR_WIDTH_DEF    = 2;
  localparam int LAYER_MAX_DEF           = 2;
  localparam int SAMPLE_ADDR_SIZE_DEF    = 10;

  localparam int Z_VEC_W_DEF = NEURON_NUM_DEF * NEURON_OUTPUT_WIDTH_DEF;
  localparam int W_VEC_W_DEF = NEURON_NUM_DEF * NEURON_NUM_DEF * WEIGHT_CELL_WIDTH_DEF;

  function automatic int z_vec_w(input int cells, input int cell_w);
    return cells * cell_w;
  endfunction

endpackage

// File: rtl/backprop_sequencer_if.sv
// rtl/backprop_sequencer_if.sv - handshake and memory buses between sequencer, backpropagator and memories
interface backprop_sequencer_if
  import bp_pkg::*;
#(
  parameter int LAYER_ADDR_WIDTH = LAYER_ADDR_WIDTH_DEF,
  parameter int SAMPLE_ADDR_SIZE = SAMPLE_ADDR_SIZE_DEF,
  parameter int Z_W              = Z_VEC_W_DEF,
  parameter int W_W              = W_VEC_W_DEF
) ();

  logic [LAYER_ADDR_WIDTH-1:0] layer;
  logic                        layer_valid;
  logic                        layer_ready;
  logic [SAMPLE_ADDR_SIZE-1:0] sample;
  logic                        sample_valid;
  logic                        sample_ready;
  logic [LAYER_ADDR_WIDTH-1:0] zmem_addr;
  logic                        zmem_rd;
  logic [Z_W-1:0]              zmem_data;
  logic [Z_W-1:0]              z;
  logic                        z_valid;
  logic                        z_ready;
  logic [Z_W-1:0]              z_prev;
  logic                        z_prev_valid;
  logic                        z_prev_ready;
  logic [W_W-1:0]              weights;
  logic                        weights_valid;
  logic                        weights_ready;
  logic                        wmem_we;
  logic [LAYER_ADDR_WIDTH-1:0] wmem_addr;
  logic [W_W-1:0]              wmem_data;
  logic                        bp_error;

  modport master (
    output layer, layer_valid, input layer_ready,
    output sample, sample_valid, input sample_ready,
    output zmem_addr, zmem_rd, input zmem_data,
    output z, z_valid, input z_ready,
    output z_prev, z_prev_valid, input z_prev_ready,
    input weights, weights_valid, output weights_ready,
    output wmem_we, wmem_addr, wmem_data,
    input bp_error
  );

  modport slave (
    input layer, layer_valid, output layer_ready,
    input sample, sample_valid, output sample_ready,
    input zmem_addr, zmem_rd, output zmem_data,
    input z, z_valid, output z_ready,
    input z_prev, z_prev_valid, output z_prev_ready,
    output weights, weights_valid, input weights_ready,
    input wmem_we, wmem_addr, wmem_data,
    output bp_error
  );

endinterface

// File: rtl/bp_vr_reg.sv
// rtl/bp_vr_reg.sv - holding register feeding one valid/ready output slot
module bp_vr_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid
);

  // Payload only changes on load, so it stays stable for the whole valid window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/backprop_sequencer.sv
// rtl/backprop_sequencer.sv - per-sample layer walk feeding the backpropagator and committing weights
// Optional BP_SEQ_ERROR_HALT_EN: stop the epoch after the current weight write once bp_error is seen.
module backprop_sequencer
  import bp_pkg::*;
#(
  parameter int NEURON_NUM          = NEURON_NUM_DEF,
  parameter int NEURON_OUTPUT_WIDTH = NEURON_OUTPUT_WIDTH_DEF,
  parameter int WEIGHT_CELL_WIDTH   = WEIGHT_CELL_WIDTH_DEF,
  parameter int LAYER_ADDR_WIDTH    = LAYER_ADDR_WIDTH_DEF,
  parameter int LAYER_MAX           = LAYER_MAX_DEF,
  parameter int SAMPLE_ADDR_SIZE    = SAMPLE_ADDR_SIZE_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SAMPLE_ADDR_SIZE-1:0] num_samples,
  output logic                        busy,
  output logic                        done,
  output logic                        error_seen,
  backprop_sequencer_if.master        bus
);

  localparam int ZW = z_vec_w(NEURON_NUM, NEURON_OUTPUT_WIDTH);
  localparam int WW = NEURON_NUM * NEURON_NUM * WEIGHT_CELL_WIDTH;
  localparam logic [LAYER_ADDR_WIDTH-1:0] L_TOP = LAYER_ADDR_WIDTH'(LAYER_MAX);
  localparam logic [LAYER_ADDR_WIDTH-1:0] L_ONE = LAYER_ADDR_WIDTH'(1);

  if (LAYER_MAX < 1) begin : g_layer_max_check
    $error("backprop_sequencer: LAYER_MAX must be at least 1");
  end

  state_t                      state, next_state;
  logic [LAYER_ADDR_WIDTH-1:0] layer_q, layer_next;
  logic [SAMPLE_ADDR_SIZE-1:0] sample_q, num_q;
  logic                        rd_z_q, rd_zp_q;
  logic                        ld_layer, ld_sample;
  logic                        accept_start, last_sample, halt;
  logic                        layer_xfer, sample_xfer, z_xfer, zp_xfer, w_xfer;
  logic [WW-1:0]               weights_in;

  assign weights_in   = bus.weights;
  assign accept_start = (state == IDLE) && start;
  assign layer_xfer   = bus.layer_valid && bus.layer_ready;
  assign sample_xfer  = bus.sample_valid && bus.sample_ready;
  assign z_xfer       = bus.z_valid && bus.z_ready;
  assign zp_xfer      = bus.z_prev_valid && bus.z_prev_ready;
  assign w_xfer       = bus.weights_valid && bus.weights_ready;
  assign last_sample  = (sample_q == num_q - SAMPLE_ADDR_SIZE'(1));

`ifdef BP_SEQ_ERROR_HALT_EN
  assign halt = error_seen;
`else
  assign halt = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    layer_next = layer_q;
    case (state)
      IDLE: begin
        if (start && num_samples != '0) begin
          next_state = LAYER;
          layer_next = L_TOP;
        end
      end
      LAYER:  if (layer_xfer) next_state = (layer_q == L_TOP) ? SAMPLE : RD_Z;
      SAMPLE: if (sample_xfer) next_state = RD_Z;
      RD_Z:   next_state = Z;
      Z:      if (z_xfer) next_state = RD_ZP;
      RD_ZP:  next_state = ZP;
      ZP:     if (zp_xfer) next_state = WGT;
      WGT:    if (w_xfer) next_state = NEXT;
      NEXT: begin
        if (halt || (layer_q == L_ONE && last_sample)) begin
          next_state = IDLE;
        end else begin
          next_state = LAYER;
          layer_next = (layer_q > L_ONE) ? layer_q - L_ONE : L_TOP;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Layer/sample slots are loaded on the transition so valid is already up on state entry.
  always_comb begin
    busy              = (state != IDLE);
    ld_layer          = (state != LAYER) && (next_state == LAYER);
    ld_sample         = (state == LAYER) && (next_state == SAMPLE);
    bus.zmem_rd       = (state == RD_Z) || (state == RD_ZP);
    bus.weights_ready = (state == WGT);
    bus.zmem_addr     = '0;
    if (state == RD_Z) begin
      bus.zmem_addr = layer_q;
    end else if (state == RD_ZP) begin
      bus.zmem_addr = layer_q - L_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_q       <= '0;
      sample_q      <= '0;
      num_q         <= '0;
      rd_z_q        <= 1'b0;
      rd_zp_q       <= 1'b0;
      done          <= 1'b0;
      error_seen    <= 1'b0;
      bus.wmem_we   <= 1'b0;
      bus.wmem_addr <= '0;
      bus.wmem_data <= '0;
    end else begin
      layer_q <= layer_next;
      rd_z_q  <= (state == RD_Z);
      rd_zp_q <= (state == RD_ZP);
      done    <= (accept_start && num_samples == '0) || (state == NEXT && next_state == IDLE);
      if (accept_start) begin
        sample_q <= '0;
        num_q    <= num_samples;
      end else if (state == NEXT && next_state == LAYER && layer_q == L_ONE) begin
        sample_q <= sample_q + SAMPLE_ADDR_SIZE'(1);
      end
      if (accept_start) begin
        error_seen <= 1'b0;
      end else if (busy && bus.bp_error) begin
        error_seen <= 1'b1;
      end
      bus.wmem_we <= w_xfer;
      if (w_xfer) begin
        bus.wmem_addr <= layer_q;
        bus.wmem_data <= weights_in;
      end
    end
  end

  bp_vr_reg #(.W(LAYER_ADDR_WIDTH)) u_layer_slot (
    .clk(clk), .rst(rst), .load(ld_layer), .load_data(layer_next),
    .ready(bus.layer_ready), .data(bus.layer), .valid(bus.layer_valid)
  );

  bp_vr_reg #(.W(SAMPLE_ADDR_SIZE)) u_sample_slot (
    .clk(clk), .rst(rst), .load(ld_sample), .load_data(sample_q),
    .ready(bus.sample_ready), .data(bus.sample), .valid(bus.sample_valid)
  );

  // Activation memory has fixed one-cycle latency: capture the cycle after the read strobe.
  bp_vr_reg #(.W(ZW)) u_z_slot (
    .clk(clk), .rst(rst), .load(rd_z_q), .load_data(bus.zmem_data),
    .ready(bus.z_ready), .data(bus.z), .valid(bus.z_valid)
  );

  bp_vr_reg #(.W(ZW)) u_z_prev_slot (
    .clk(clk), .rst(rst), .load(rd_zp_q), .load_data(bus.zmem_data),
    .ready(bus.z_prev_ready), .data(bus.z_prev), .valid(bus.z_prev_valid)
  );

endmodule

// File: tb/tb_backprop_sequencer.sv
// tb/tb_backprop_sequencer.sv - directed scoreboard bench for backprop_sequencer
module tb_backprop_sequencer;
  import bp_pkg::*;

  localparam int LA   = 2;
  localparam int SA   = 10;
  localparam int ZW   = 40;
  localparam int WW   = 256;
  localparam int LMAX = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [SA-1:0] num_samples = '0;
  logic          busy, done, error_seen;

  backprop_sequencer_if #(.LAYER_ADDR_WIDTH(LA), .SAMPLE_ADDR_SIZE(SA), .Z_W(ZW), .W_W(WW)) bus ();

  backprop_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .busy(busy), .done(done), .error_seen(error_seen), .bus(bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  logic [LA-1:0] cur_l = '0;
  logic [SA-1:0] cur_s = '0;
  logic [255:0]  q_layer[$], q_sample[$], q_rd[$], q_z[$], q_zp[$], q_waddr[$], q_wdata[$];

  function automatic logic [ZW-1:0] ztag(input int a);
    return {4{10'h200 | 10'(a)}};
  endfunction

  function automatic logic [WW-1:0] wfun(input int l, input int s);
    return {16{4'hA, 2'(l), 10'(s)}};
  endfunction

  assign bus.weights = wfun(int'(cur_l), int'(cur_s));

  always @(posedge clk) begin
    if (bus.zmem_rd) bus.zmem_data <= ztag(int'(bus.zmem_addr));
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qleft();
    return q_layer.size() + q_sample.size() + q_rd.size() + q_z.size() + q_zp.size() + q_waddr.size();
  endfunction

  task automatic clear_queues();
    q_layer.delete(); q_sample.delete(); q_rd.delete();
    q_z.delete(); q_zp.delete(); q_waddr.delete(); q_wdata.delete();
  endtask

  task automatic expect_epoch(input int n, input int halt_first);
    for (int s = 0; s < n; s++) begin
      for (int l = LMAX; l >= 1; l--) begin
        q_layer.push_back(256'(l));
        if (l == LMAX) q_sample.push_back(256'(s));
        q_rd.push_back(256'(l));
        q_rd.push_back(256'(l - 1));
        q_z.push_back(256'(ztag(l)));
        q_zp.push_back(256'(ztag(l - 1)));
        q_waddr.push_back(256'(l));
        q_wdata.push_back(256'(wfun(l, s)));
        if (halt_first != 0) return;
      end
    end
  endtask

  // Monitor: every handshake and memory access is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.layer_valid && bus.layer_ready) begin
        if (q_layer.size() == 0) chk("layer_extra", 256'(q_layer.size()), 256'(1));
        else chk("layer", 256'(bus.layer), q_layer.pop_front());
        cur_l = bus.layer;
      end
      if (bus.sample_valid && bus.sample_ready) begin
        if (q_sample.size() == 0) chk("sample_extra", 256'(q_sample.size()), 256'(1));
        else chk("sample", 256'(bus.sample), q_sample.pop_front());
        cur_s = bus.sample;
      end
      if (bus.zmem_rd) begin
        if (q_rd.size() == 0) chk("zmem_rd_extra", 256'(q_rd.size()), 256'(1));
        else chk("zmem_addr", 256'(bus.zmem_addr), q_rd.pop_front());
      end
      if (bus.z_valid && bus.z_ready) begin
        if (q_z.size() == 0) chk("z_extra", 256'(q_z.size()), 256'(1));
        else chk("z_data", 256'(bus.z), q_z.pop_front());
      end
      if (bus.z_prev_valid && bus.z_prev_ready) begin
        if (q_zp.size() == 0) chk("z_prev_extra", 256'(q_zp.size()), 256'(1));
        else chk("z_prev_data", 256'(bus.z_prev), q_zp.pop_front());
      end
      if (bus.wmem_we) begin
        wr_cnt++;
        if (q_waddr.size() == 0) chk("wmem_extra", 256'(q_waddr.size()), 256'(1));
        else begin
          chk("wmem_addr", 256'(bus.wmem_addr), q_waddr.pop_front());
          chk("wmem_data", 256'(bus.wmem_data), q_wdata.pop_front());
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic pulse_start(input int n);
    @(negedge clk);
    num_samples = SA'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, 256'(seen), 256'(1));
    @(negedge clk);
    chk({tag, "_busy_after_done"}, 256'(busy), 256'(0));
    chk({tag, "_done_one_cycle"}, 256'(done), 256'(0));
  endtask

  task automatic wait_wgt(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (bus.weights_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_wgt_reached"}, 256'(seen), 256'(1));
  endtask

  initial begin
    logic [ZW-1:0] z_hold;
    bit            zv_seen;
    bus.layer_ready   = 1'b1;
    bus.sample_ready  = 1'b1;
    bus.z_ready       = 1'b1;
    bus.z_prev_ready  = 1'b1;
    bus.weights_valid = 1'b1;
    bus.bp_error      = 1'b0;
    bus.zmem_data     = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_error_seen", 256'(error_seen), 256'(0));
    chk("rst_layer_valid", 256'(bus.layer_valid), 256'(0));
    chk("rst_sample_valid", 256'(bus.sample_valid), 256'(0));
    chk("rst_z_valid", 256'(bus.z_valid), 256'(0));
    chk("rst_z_prev_valid", 256'(bus.z_prev_valid), 256'(0));
    chk("rst_zmem_rd", 256'(bus.zmem_rd), 256'(0));
    chk("rst_wmem_we", 256'(bus.wmem_we), 256'(0));
    chk("rst_weights_ready", 256'(bus.weights_ready), 256'(0));
    chk("rst_z", 256'(bus.z), 256'(0));
    chk("rst_wmem_data", 256'(bus.wmem_data), 256'(0));
    rst = 1'b0;

    // single sample, everything ready
    done_cnt = 0; wr_cnt = 0;
    expect_epoch(1, 0);
    pulse_start(1);
    chk("t1_busy", 256'(busy), 256'(1));
    wait_done("t1");
    chk("t1_queues_empty", 256'(qleft()), 256'(0));
    chk("t1_done_cnt", 256'(done_cnt), 256'(1));
    chk("t1_wr_cnt", 256'(wr_cnt), 256'(2));

    // three samples, with a start pulse mid-epoch that must be ignored
    done_cnt = 0; wr_cnt = 0;
    expect_epoch(3, 0);
    pulse_start(3);
    repeat (10) @(negedge clk);
    num_samples = SA'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t2_busy_mid", 256'(busy), 256'(1));
    wait_done("t2");
    chk("t2_queues_empty", 256'(qleft()), 256'(0));
    chk("t2_done_cnt", 256'(done_cnt), 256'(1));
    chk("t2_wr_cnt", 256'(wr_cnt), 256'(6));

    // z consumer stalls for 5 cycles
    done_cnt = 0; wr_cnt = 0;
    bus.z_ready = 1'b0;
    expect_epoch(1, 0);
    pulse_start(1);
    zv_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.z_valid) begin
        zv_seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("t3_z_valid_seen", 256'(zv_seen), 256'(1));
    z_hold = bus.z;
    chk("t3_z_first", 256'(z_hold), 256'(ztag(2)));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_z_valid_hold", 256'(bus.z_valid), 256'(1));
      chk("t3_z_stable", 256'(bus.z), 256'(z_hold));
      chk("t3_no_zmem_rd", 256'(bus.zmem_rd), 256'(0));
    end
    @(posedge clk);
    #1 bus.z_ready = 1'b1;
    wait_done("t3");
    chk("t3_queues_empty", 256'(qleft()), 256'(0));
    chk("t3_wr_cnt", 256'(wr_cnt), 256'(2));

    // empty epoch
    done_cnt = 0;
    pulse_start(0);
    chk("t4_done_next", 256'(done), 256'(1));
    chk("t4_busy", 256'(busy), 256'(0));
    @(negedge clk);
    chk("t4_done_clear", 256'(done), 256'(0));
    repeat (3) @(negedge clk);
    chk("t4_done_cnt", 256'(done_cnt), 256'(1));

    // backpropagator error during the first weight fetch
    done_cnt = 0; wr_cnt = 0;
`ifdef BP_SEQ_ERROR_HALT_EN
    expect_epoch(1, 1);
`else
    expect_epoch(1, 0);
`endif
    pulse_start(1);
    wait_wgt("t5");
    bus.bp_error = 1'b1;
    @(negedge clk);
    bus.bp_error = 1'b0;
    wait_done("t5");
    chk("t5_error_seen", 256'(error_seen), 256'(1));
    chk("t5_queues_empty", 256'(qleft()), 256'(0));
    chk("t5_done_cnt", 256'(done_cnt), 256'(1));
`ifdef BP_SEQ_ERROR_HALT_EN
    chk("t5_wr_cnt", 256'(wr_cnt), 256'(1));
`else
    chk("t5_wr_cnt", 256'(wr_cnt), 256'(2));
`endif

    // reset while waiting for weights, then a clean epoch
    wr_cnt = 0;
    expect_epoch(1, 0);
    bus.weights_valid = 1'b0;
    pulse_start(1);
    chk("t6_error_cleared_by_start", 256'(error_seen), 256'(0));
    wait_wgt("t6");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_busy", 256'(busy), 256'(0));
    chk("t6_weights_ready", 256'(bus.weights_ready), 256'(0));
    chk("t6_wmem_we", 256'(bus.wmem_we), 256'(0));
    chk("t6_layer_valid", 256'(bus.layer_valid), 256'(0));
    chk("t6_z_valid", 256'(bus.z_valid), 256'(0));
    chk("t6_z", 256'(bus.z), 256'(0));
    chk("t6_done", 256'(done), 256'(0));
    @(posedge clk);
    #1;
    chk("t6_wmem_we_held", 256'(bus.wmem_we), 256'(0));
    chk("t6_wr_cnt_none", 256'(wr_cnt), 256'(0));
    clear_queues();
    @(negedge clk);
    rst = 1'b0;
    bus.weights_valid = 1'b1;
    done_cnt = 0; wr_cnt = 0;
    expect_epoch(1, 0);
    pulse_start(1);
    wait_done("t6");
    chk("t6_queues_empty", 256'(qleft()), 256'(0));
    chk("t6_done_cnt", 256'(done_cnt), 256'(1));
    chk("t6_wr_cnt", 256'(wr_cnt), 256'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
